// File: rtl/integral_seq_ctrl.sv
//-----------------------------------------------------------------------------
// integral_seq_ctrl
//
// Frame sequencer for the column-pair integral pipeline. On start it walks the
// beats j = 0 .. NUM_COLS/2 and issues one column-pair memory read per beat,
// throttled by result-FIFO credit and stopped early by abort. The read is
// forwarded one cycle later to the magnitude-square datapath. A 5-stage tag
// pipeline follows each beat until its result returns on dp_ready, where the
// returned indices are checked and the result is pushed into the result FIFO.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   start, abort             frame start pulse / stop issuing new beats
//   mem_rd_en, mem_rd_idx1/2 column memory read strobe and pair addresses
//   dp_valid, dp_index_col_* datapath request (memory strobe delayed 1 cycle)
//   dp_ready, dp_out_index_* datapath result strobe and returned indices
//   res_push, res_col2_vld   result FIFO write enable, col_2-meaningful flag
//   rf_pop                   downstream removed one result FIFO entry
//   busy, done               frame in progress / 1-cycle completion pulse
//   err_idx, err_credit      sticky index-mismatch / credit-overflow flags
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module integral_seq_ctrl #(
    parameter int NUM_COLS = 2048,
    parameter int RF_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        mem_rd_en,
    output logic [10:0] mem_rd_idx1,
    output logic [10:0] mem_rd_idx2,
    output logic        dp_valid,
    output logic [10:0] dp_index_col_1,
    output logic [10:0] dp_index_col_2,
    input  logic        dp_ready,
    input  logic [10:0] dp_out_index_col1,
    input  logic [10:0] dp_out_index_col2,
    output logic        res_push,
    output logic        res_col2_vld,
    input  logic        rf_pop,
    output logic        busy,
    output logic        done,
    output logic        err_idx,
    output logic        err_credit
);

    // Stage 0 is the datapath request register; stage TAG_LEN-1 lines up
    // with dp_ready (issue + 5 cycles).
    localparam int          TAG_LEN      = 5;
    localparam logic [10:0] HALF         = 11'(NUM_COLS / 2);
    localparam logic [10:0] NCOLS_M1     = 11'(NUM_COLS - 1);
    localparam logic [3:0]  CREDIT_MAX   = 4'(RF_DEPTH);
    localparam logic [2:0]  INFLIGHT_MAX = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [10:0] r_beat;
    logic [3:0]  r_credit;
    logic [2:0]  r_inflight;
    logic [2:0]  w_inflight_nxt;
    logic        r_err_idx;
    logic        r_err_credit;

    logic [TAG_LEN-1:0]       r_tag_vld;
    logic [TAG_LEN-1:0]       r_tag_c2;
    logic [TAG_LEN-1:0][10:0] r_tag_i1;
    logic [TAG_LEN-1:0][10:0] r_tag_i2;

    logic        w_start_ok;
    logic        w_issue;
    logic        w_last_beat;
    logic        w_ret;
    logic        w_idx_bad;
    logic        w_credit_ovf;
    logic [21:0] w_pair;
    logic        w_pair_c2;

    // Column pair for beat j. NUM_COLS - j is formed as (NUM_COLS-1) - j + 1
    // so the arithmetic stays 11 bits wide even for NUM_COLS = 2048.
    function automatic logic [21:0] beat_pair(input logic [10:0] j);
        logic [10:0] mirror;
        mirror = NCOLS_M1 - j + 11'd1;
        if (j == 11'd0) begin
            return {11'd0, 11'd0};
        end else if (j == HALF) begin
            return {HALF, 11'd0};
        end else begin
            return {j, mirror};
        end
    endfunction

    // Shared control strobes for the current cycle.
    always_comb begin
        w_start_ok   = start && (r_state == S_IDLE);
        w_issue      = (r_state == S_ISSUE) && (r_credit != 4'd0) && !abort && !rst;
        w_last_beat  = w_issue && (r_beat == HALF);
        // A dp_ready with no matching tag (e.g. left over from before a reset)
        // is not a result of this frame and is ignored everywhere.
        w_ret        = dp_ready && r_tag_vld[TAG_LEN-1];
        w_idx_bad    = w_ret && ((dp_out_index_col1 != r_tag_i1[TAG_LEN-1]) ||
                                 (dp_out_index_col2 != r_tag_i2[TAG_LEN-1]));
        w_credit_ovf = rf_pop && !w_issue && (r_credit == CREDIT_MAX);
        w_pair       = beat_pair(r_beat);
        w_pair_c2    = (r_beat != 11'd0) && (r_beat != HALF);
    end

    // In-flight count after this cycle's issue/return; drain completion is
    // decided on this value so done comes one cycle after the last return.
    always_comb begin
        w_inflight_nxt = r_inflight;
        case ({w_issue, w_ret})
            2'b10:   w_inflight_nxt = (r_inflight == INFLIGHT_MAX) ? r_inflight : r_inflight + 3'd1;
            2'b01:   w_inflight_nxt = (r_inflight == 3'd0) ? r_inflight : r_inflight - 3'd1;
            default: w_inflight_nxt = r_inflight;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = start ? S_ISSUE : S_IDLE;
            S_ISSUE: w_state_nxt = (w_last_beat || abort) ? S_DRAIN : S_ISSUE;
            S_DRAIN: w_state_nxt = (w_inflight_nxt == 3'd0) ? S_DONE : S_DRAIN;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs; everything is forced low while reset is asserted.
    always_comb begin
        mem_rd_en    = w_issue;
        mem_rd_idx1  = w_issue ? w_pair[21:11] : 11'd0;
        mem_rd_idx2  = w_issue ? w_pair[10:0]  : 11'd0;
        busy         = !rst && (r_state != S_IDLE);
        done         = !rst && (r_state == S_DONE);
        res_push     = !rst && w_ret;
        res_col2_vld = !rst && w_ret && r_tag_c2[TAG_LEN-1];
    end

    // Beat counter: cleared by an accepted start, advances only on issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= 11'd0;
        end else if (w_start_ok) begin
            r_beat <= 11'd0;
        end else if (w_issue) begin
            r_beat <= r_beat + 11'd1;
        end else begin
            r_beat <= r_beat;
        end
    end

    // Result FIFO credit; a pop that would exceed capacity is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit <= CREDIT_MAX;
        end else begin
            case ({w_issue, rf_pop})
                2'b10:   r_credit <= r_credit - 4'd1;
                2'b01:   r_credit <= (r_credit == CREDIT_MAX) ? r_credit : r_credit + 4'd1;
                default: r_credit <= r_credit;
            endcase
        end
    end

    // In-flight beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 3'd0;
        end else begin
            r_inflight <= w_inflight_nxt;
        end
    end

    // Tag pipeline: per-beat valid, expected indices and col_2 flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld <= '0;
            r_tag_c2  <= '0;
            r_tag_i1  <= '0;
            r_tag_i2  <= '0;
        end else begin
            r_tag_vld <= {r_tag_vld[TAG_LEN-2:0], w_issue};
            r_tag_c2  <= {r_tag_c2[TAG_LEN-2:0],  w_issue && w_pair_c2};
            r_tag_i1  <= {r_tag_i1[TAG_LEN-2:0],  mem_rd_idx1};
            r_tag_i2  <= {r_tag_i2[TAG_LEN-2:0],  mem_rd_idx2};
        end
    end

    // Sticky error flags; a new error in the start cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_idx    <= 1'b0;
            r_err_credit <= 1'b0;
        end else begin
            if (w_idx_bad) begin
                r_err_idx <= 1'b1;
            end else if (w_start_ok) begin
                r_err_idx <= 1'b0;
            end else begin
                r_err_idx <= r_err_idx;
            end
            if (w_credit_ovf) begin
                r_err_credit <= 1'b1;
            end else if (w_start_ok) begin
                r_err_credit <= 1'b0;
            end else begin
                r_err_credit <= r_err_credit;
            end
        end
    end

    // Datapath request is tag stage 0 (indices are zero when not issuing).
    assign dp_valid       = r_tag_vld[0];
    assign dp_index_col_1 = r_tag_i1[0];
    assign dp_index_col_2 = r_tag_i2[0];
    assign err_idx        = r_err_idx;
    assign err_credit     = r_err_credit;

endmodule

// File: tb/tb_integral_seq_ctrl.sv
//-----------------------------------------------------------------------------
// tb_integral_seq_ctrl
//
// Directed bench: u_dut (NUM_COLS=8, RF_DEPTH=8) is checked per cycle against
// a table of hand-computed outputs, plus hand-written abort, index-corruption
// and mid-frame reset sequences. u_dut2 (NUM_COLS=8, RF_DEPTH=2) covers credit
// stalling and the credit-overflow flag. Each DUT has an ideal 4-cycle
// datapath model that echoes the requested indices.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_integral_seq_ctrl;

    logic        clk;
    logic        rst;

    // u_dut signals
    logic        start, abort, rf_pop, dp_ready;
    logic        mem_rd_en, dp_valid, res_push, res_col2_vld, busy, done, err_idx, err_credit;
    logic [10:0] mem_rd_idx1, mem_rd_idx2, dp_index_col_1, dp_index_col_2;
    logic [10:0] dp_out1, dp_out2;

    // u_dut2 signals
    logic        s2_start, s2_abort, s2_pop, s2_dp_ready;
    logic        s2_en, s2_dv, s2_push, s2_c2, s2_busy, s2_done, s2_eidx, s2_ecr;
    logic [10:0] s2_i1, s2_i2, s2_dpi1, s2_dpi2, s2_out1, s2_out2;

    // Datapath models
    logic             corrupt = 1'b0;
    logic [3:0]       m_v  = '0;
    logic [3:0][10:0] m_i1 = '0;
    logic [3:0][10:0] m_i2 = '0;
    logic [3:0]       m2_v  = '0;
    logic [3:0][10:0] m2_i1 = '0;
    logic [3:0][10:0] m2_i2 = '0;

    int n_vec = 0;
    int n_bad = 0;
    int n_iss, n_push, n_done, n_err;

    typedef struct {
        logic        st;
        logic        ab;
        logic        pop;
        logic [29:0] exp;
    } vec_t;

    vec_t tbl [12];

    integral_seq_ctrl #(.NUM_COLS(8), .RF_DEPTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .mem_rd_en(mem_rd_en), .mem_rd_idx1(mem_rd_idx1), .mem_rd_idx2(mem_rd_idx2),
        .dp_valid(dp_valid), .dp_index_col_1(dp_index_col_1), .dp_index_col_2(dp_index_col_2),
        .dp_ready(dp_ready), .dp_out_index_col1(dp_out1), .dp_out_index_col2(dp_out2),
        .res_push(res_push), .res_col2_vld(res_col2_vld), .rf_pop(rf_pop),
        .busy(busy), .done(done), .err_idx(err_idx), .err_credit(err_credit)
    );

    integral_seq_ctrl #(.NUM_COLS(8), .RF_DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(s2_start), .abort(s2_abort),
        .mem_rd_en(s2_en), .mem_rd_idx1(s2_i1), .mem_rd_idx2(s2_i2),
        .dp_valid(s2_dv), .dp_index_col_1(s2_dpi1), .dp_index_col_2(s2_dpi2),
        .dp_ready(s2_dp_ready), .dp_out_index_col1(s2_out1), .dp_out_index_col2(s2_out2),
        .res_push(s2_push), .res_col2_vld(s2_c2), .rf_pop(s2_pop),
        .busy(s2_busy), .done(s2_done), .err_idx(s2_eidx), .err_credit(s2_ecr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal datapath: result 4 clocks after dp_valid; optional col1 corruption of beat j=2.
    always @(posedge clk) begin
        m_v   <= {m_v[2:0], dp_valid};
        m_i1  <= {m_i1[2:0], dp_index_col_1 ^ ((corrupt && dp_valid && dp_index_col_1 == 11'd2) ? 11'h400 : 11'h000)};
        m_i2  <= {m_i2[2:0], dp_index_col_2};
        m2_v  <= {m2_v[2:0], s2_dv};
        m2_i1 <= {m2_i1[2:0], s2_dpi1};
        m2_i2 <= {m2_i2[2:0], s2_dpi2};
    end

    assign dp_ready    = m_v[3];
    assign dp_out1     = m_i1[3];
    assign dp_out2     = m_i2[3];
    assign s2_dp_ready = m2_v[3];
    assign s2_out1     = m2_i1[3];
    assign s2_out2     = m2_i2[3];

    function automatic logic [29:0] pk(input logic en, input logic [10:0] a, input logic [10:0] b,
                                       input logic dv, input logic push, input logic c2,
                                       input logic bz, input logic dn, input logic ei, input logic ec);
        return {en, a, b, dv, push, c2, bz, dn, ei, ec};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_table(input string tag);
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start  = tbl[i].st;
            abort  = tbl[i].ab;
            rf_pop = tbl[i].pop;
            #1;
            chk($sformatf("%s_row%0d", tag, i),
                {2'b00, pk(mem_rd_en, mem_rd_idx1, mem_rd_idx2, dp_valid, res_push,
                           res_col2_vld, busy, done, err_idx, err_credit)},
                {2'b00, tbl[i].exp});
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; rf_pop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            st    ab    pop         en    i1     i2     dv    push  c2    busy  done  ei    ec
        tbl[0]  = '{1'b0, 1'b0, 1'b0, pk(1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, pk(1'b1, 11'd1, 11'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, pk(1'b1, 11'd2, 11'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, pk(1'b1, 11'd3, 11'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, pk(1'b1, 11'd4, 11'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, pk(1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, pk(1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, pk(1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, pk(1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, pk(1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[10] = '{1'b0, 1'b0, 1'b0, pk(1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
        tbl[11] = '{1'b0, 1'b0, 1'b0, pk(1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};

        rst = 1'b1;
        start = 1'b0; abort = 1'b0; rf_pop = 1'b0;
        s2_start = 1'b0; s2_abort = 1'b0; s2_pop = 1'b0;

        // Reset state of both instances
        repeat (3) @(negedge clk);
        #1;
        chk("reset_dut1", {2'b00, pk(mem_rd_en, mem_rd_idx1, mem_rd_idx2, dp_valid, res_push,
                                     res_col2_vld, busy, done, err_idx, err_credit)}, 32'd0);
        chk("reset_dut2", {2'b00, pk(s2_en, s2_i1, s2_i2, s2_dv, s2_push, s2_c2,
                                     s2_busy, s2_done, s2_eidx, s2_ecr)}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_after_reset", {2'b00, pk(mem_rd_en, mem_rd_idx1, mem_rd_idx2, dp_valid, res_push,
                                           res_col2_vld, busy, done, err_idx, err_credit)}, 32'd0);

        // Pop with credit full sets err_credit; the table's start then clears it
        @(negedge clk); rf_pop = 1'b1;
        @(negedge clk); rf_pop = 1'b0;
        #1;
        chk("credit_ovf_dut1", {31'd0, err_credit}, 32'd1);

        // Full frame, with a start pulse during ISSUE that must be ignored
        run_table("frame");

        // Abort in the cycle after the 2nd issue
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
        chk("abort_c0", {9'd0, mem_rd_en, mem_rd_idx1, mem_rd_idx2}, {9'd0, 1'b1, 11'd0, 11'd0});
        @(negedge clk);
        #1;
        chk("abort_c1", {9'd0, mem_rd_en, mem_rd_idx1, mem_rd_idx2}, {9'd0, 1'b1, 11'd1, 11'd7});
        @(negedge clk); abort = 1'b1;
        #1;
        chk("abort_blocks_issue", {31'd0, mem_rd_en}, 32'd0);
        n_iss = 0; n_push = 0; n_done = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            abort = 1'b0; rf_pop = 1'b0;
            #1;
            if (mem_rd_en) n_iss++;
            if (done) n_done++;
            if (res_push) begin
                n_push++;
                rf_pop = 1'b1;
            end
        end
        chk("abort_no_more_issue", n_iss, 32'd0);
        chk("abort_push_count", n_push, 32'd2);
        chk("abort_done_count", n_done, 32'd1);
        chk("abort_busy_low", {31'd0, busy}, 32'd0);

        // Corrupted col1 index on beat j=2 (returns in frame cycle 7)
        @(negedge clk); rf_pop = 1'b0; corrupt = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            rf_pop = 1'b0;
            #1;
            if (c == 7) chk("err_idx_before", {31'd0, err_idx}, 32'd0);
            if (c == 8) chk("err_idx_set", {31'd0, err_idx}, 32'd1);
            if (res_push) rf_pop = 1'b1;
        end
        corrupt = 1'b0;
        repeat (3) @(negedge clk);
        rf_pop = 1'b0;
        #1;
        chk("err_idx_held", {31'd0, err_idx}, 32'd1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
        chk("err_idx_cleared_by_start", {31'd0, err_idx}, 32'd0);
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rf_pop = 1'b0;
            #1;
            if (done) n_done++;
            if (res_push) rf_pop = 1'b1;
        end
        chk("clean_frame_err_idx", {31'd0, err_idx}, 32'd0);
        chk("clean_frame_done", n_done, 32'd1);
        @(negedge clk); rf_pop = 1'b0;

        // RF_DEPTH=2: pop at full is ignored, then only 2 beats, then 1 per pop
        @(negedge clk); s2_pop = 1'b1;
        @(negedge clk); s2_pop = 1'b0;
        #1;
        chk("credit_ovf_dut2", {31'd0, s2_ecr}, 32'd1);
        @(negedge clk); s2_start = 1'b1;
        @(negedge clk); s2_start = 1'b0;
        n_iss = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (c == 0) chk("credit_ovf_cleared", {31'd0, s2_ecr}, 32'd0);
            if (s2_en) n_iss++;
        end
        chk("credit_stall_count", n_iss, 32'd2);
        @(negedge clk); s2_pop = 1'b1;
        #1;
        chk("pop_cycle_no_issue", {31'd0, s2_en}, 32'd0);
        @(negedge clk); s2_pop = 1'b0;
        #1;
        chk("pop_releases_beat2", {9'd0, s2_en, s2_i1, s2_i2}, {9'd0, 1'b1, 11'd2, 11'd6});
        @(negedge clk);
        #1;
        chk("single_beat_per_pop", {31'd0, s2_en}, 32'd0);

        // Reset with 3 beats in flight; trailing dp_ready must be ignored
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_to_idle", {30'd0, busy, mem_rd_en}, 32'd0);
        n_push = 0; n_err = 0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (res_push) n_push++;
            if (err_idx || err_credit) n_err++;
        end
        chk("rst_trailing_push", n_push, 32'd0);
        chk("rst_trailing_err", n_err, 32'd0);

        // Normal frame again after the mid-frame reset
        repeat (4) @(negedge clk);
        run_table("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/integral_seq_ctrl.md
INTEGRAL_SEQ_CTRL -- requirements
Module: integral_seq_ctrl

Interface
REQ-001 SHALL use a single clock domain: one clock clk; reset rst is synchronous and active-high.
REQ-002 SHALL have parameter NUM_COLS, default 2048, giving columns per frame; even, 4..2048.
REQ-003 SHALL have parameter RF_DEPTH, default 8, giving result FIFO capacity in entries; range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port start, input, 1 bit: frame start pulse.
REQ-007 SHALL have port abort, input, 1 bit: stop issuing new beats.
REQ-008 SHALL have port mem_rd_en, output, 1 bit: column memory read strobe; data returns 1 cycle later.
REQ-009 SHALL have ports mem_rd_idx1 and mem_rd_idx2, outputs, 11 bits each: column pair read addresses.
REQ-010 SHALL have port dp_valid, output, 1 bit: valid to the magnitude-square datapath.
REQ-011 SHALL have ports dp_index_col_1 and dp_index_col_2, outputs, 11 bits each: indices to the datapath.
REQ-012 SHALL have port dp_ready, input, 1 bit: datapath result strobe, 4 clk after dp_valid.
REQ-013 SHALL have ports dp_out_index_col1 and dp_out_index_col2, inputs, 11 bits each: indices returned by the datapath.
REQ-014 SHALL have port res_push, output, 1 bit: result FIFO write enable.
REQ-015 SHALL have port res_col2_vld, output, 1 bit: col_2 of the pushed entry is meaningful.
REQ-016 SHALL have port rf_pop, input, 1 bit: downstream removed one result FIFO entry.
REQ-017 SHALL have ports busy, output, 1 bit (frame in progress), and done, output, 1 bit (1-cycle frame-complete pulse).
REQ-018 SHALL have ports err_idx and err_credit, outputs, 1 bit each: sticky index-mismatch and credit-overflow flags.

Function
REQ-019 SHALL sequence beats j = 0..NUM_COLS/2 (NUM_COLS/2+1 beats) as follows: j=0 -> (0,0), col2_vld=0; 1<=j<NUM_COLS/2 -> (j, NUM_COLS-j), col2_vld=1; j=NUM_COLS/2 -> (NUM_COLS/2, 0), col2_vld=0.
REQ-020 SHALL have FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-021 IDLE->ISSUE SHALL occur on start: beat counter cleared; busy=1 from the next cycle.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 In ISSUE, the block SHALL issue one beat per cycle (mem_rd_en=1) iff credit>0 and abort=0; otherwise it SHALL stall with no skipped beats.
REQ-024 ISSUE->DRAIN SHALL occur in the cycle the last beat issues, or on abort.
REQ-025 DRAIN->DONE SHALL occur when in-flight count = 0.
REQ-026 DONE SHALL pulse done=1 for one cycle, then go to IDLE with busy=0.
REQ-027 dp_valid and dp_index_col_* SHALL be mem_rd_en and mem_rd_idx* registered by one cycle; they SHALL be 0 otherwise.
REQ-028 In-flight counter: +1 on mem_rd_en, -1 on dp_ready; simultaneous events leave it unchanged; maximum 6.
REQ-029 Credit counter SHALL start at RF_DEPTH, -1 per issue and +1 per rf_pop; simultaneous events leave it unchanged.
REQ-030 rf_pop when credit=RF_DEPTH with no issue SHALL be ignored and set err_credit.
REQ-031 res_push SHALL equal dp_ready combinationally.
REQ-032 res_col2_vld SHALL come from a tag pipeline aligned to dp_ready (5-cycle delay from issue).
REQ-033 On dp_ready, dp_out_index_col1/2 SHALL be compared with the expected pair in the tag pipeline; any mismatch SHALL set err_idx.
REQ-034 err_idx and err_credit SHALL be cleared only by rst or by start accepted in IDLE.
REQ-035 Beats issued before an abort SHALL still drain and push; done SHALL still pulse.

Reset
REQ-036 While rst=1 at a clk edge: state=IDLE; all counters 0; credit=RF_DEPTH; tag pipeline cleared.
REQ-037 While rst=1 at a clk edge: mem_rd_en, dp_valid, res_push, busy, done, err_* = 0; all index outputs = 0.
REQ-038 rst mid-frame SHALL discard all in-flight state; dp_ready pulses arriving afterwards SHALL be ignored (no res_push, no error).

Verification
REQ-039 Scenario NUM_COLS=8, RF_DEPTH=8, ideal datapath model, start -> 5 consecutive issues with pairs (0,0),(1,7),(2,6),(3,5),(4,0); res_col2_vld = 0,1,1,1,0; done exactly 10 cycles after the first mem_rd_en.
REQ-040 Scenario RF_DEPTH=2, no rf_pop -> exactly 2 beats issue then stall; one rf_pop -> exactly one more beat issues on the next cycle.
REQ-041 Scenario abort asserted in the cycle after the 2nd issue -> no 3rd issue; 2 res_push; done pulses; busy falls.
REQ-042 Scenario datapath model corrupts the returned col1 index of beat 2 -> err_idx=1 from the next cycle and held until start.
REQ-043 Scenario rf_pop with credit full -> err_credit=1 and credit unchanged; start during ISSUE -> no effect on beat order.
REQ-044 Scenario rst asserted with 3 beats in flight -> IDLE next cycle; trailing dp_ready -> res_push stays 0.
